// File: rtl/cr_kme_fifo_arb_pkg.sv
// Shared types and default widths for the KME FIFO write-port arbiter.
package cr_kme_fifo_arb_pkg;

  // Arbiter FSM encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB_IDLE   = 1'b0;  // no owner, arbitrating
  localparam arb_state_t ARB_LOCKED = 1'b1;  // owner = grant_id, mid-packet

  // Default geometry of the KME write datapath.
  localparam int ARB_NUM_REQ_DEF     = 4;
  localparam int ARB_DATA_SIZE_DEF   = 132;
  localparam int ARB_ID_W_DEF        = 3;
  localparam int ARB_WDOG_CYCLES_DEF = 1024;

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, modulo N.
// Purely combinational; ptr must be below N.
module cr_kme_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk the rotated request vector; the first hit is un-rotated into idx.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise an
    // unmatched path would hold its old value and infer a latch.
    int c;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// Packet-aware round-robin arbiter in front of a cr_kme FIFO write port.
// A requester keeps the grant until its eop beat has been written, so
// packets never interleave in the FIFO.
// Optional: define CR_KME_FIFO_ARB_WDOG_EN to add a lock watchdog
// (parameter WDOG_CYCLES, output wdog_err) that frees a silent owner.
module cr_kme_fifo_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ_DEF,    // 2..8
  parameter int DATA_SIZE = ARB_DATA_SIZE_DEF,  // matches the FIFO
  parameter int ID_W      = ARB_ID_W_DEF        // 2**ID_W >= NUM_REQ
`ifdef CR_KME_FIFO_ARB_WDOG_EN
  ,
  parameter int WDOG_CYCLES = ARB_WDOG_CYCLES_DEF
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_eop,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [DATA_SIZE-1:0]         fifo_in,
  output logic                         fifo_in_valid,
  input  logic                         fifo_in_stall,
`ifdef CR_KME_FIFO_ARB_WDOG_EN
  output logic                         wdog_err,
`endif
  output logic [ID_W-1:0]              grant_id,
  output logic                         locked
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;

  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic [ID_W-1:0] sel;
  logic            sel_valid;
  logic            sel_eop;
  logic            owner_valid;

  // Next round-robin start after index v, wrapping at NUM_REQ-1.
  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  cr_kme_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner's valid, looked up by compare so grant_id may be wider than needed.
  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) owner_valid = req_valid[i];
    end
  end

  // While locked only the owner may write; otherwise the fresh winner.
  assign locked    = (state == ARB_LOCKED);
  assign sel       = locked ? grant_id : pick_idx;
  assign sel_valid = locked ? owner_valid : pick_found;

  // Issue is suppressed during reset so nothing reaches the FIFO while
  // the arbiter is being cleared, even with requesters still valid.
  assign fifo_in_valid = rst_n & sel_valid & ~fifo_in_stall;

  // Zero-latency write mux and one-hot acknowledge for the selected lane.
  always_comb begin
    fifo_in = '0;
    sel_eop = 1'b0;
    req_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        fifo_in    = req_data[i*DATA_SIZE +: DATA_SIZE];
        sel_eop    = req_eop[i];
        req_ack[i] = fifo_in_valid;
      end
    end
  end

`ifdef CR_KME_FIFO_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_fire;

  // Fires on the WDOG_CYCLES-th consecutive silent cycle of the owner.
  assign wdog_fire = locked && !owner_valid &&
                     (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Silent-owner counter; any owner beat or leaving LOCKED clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_fire;
      if (locked && !owner_valid && !wdog_fire) wdog_cnt <= wdog_cnt + 1'b1;
      else                                      wdog_cnt <= '0;
    end
  end
`endif

  // Arbiter FSM: lock on a non-eop beat, release and advance on eop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else if (fifo_in_valid) begin
      grant_id <= sel;
      if (sel_eop) begin
        state  <= ARB_IDLE;
        rr_ptr <= inc_wrap(sel);
      end else begin
        state  <= ARB_LOCKED;
      end
    end
`ifdef CR_KME_FIFO_ARB_WDOG_EN
    else if (wdog_fire) begin
      state  <= ARB_IDLE;
      rr_ptr <= inc_wrap(grant_id);
    end
`endif
  end

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Directed self-checking bench for cr_kme_fifo_arb (NUM_REQ=4).
// Inputs change 1ns after the rising edge; combinational outputs are
// checked 2ns after the edge, registered outputs 1ns after it.
module tb_cr_kme_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 132;
  localparam int IW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_eop;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   fifo_in;
  logic            fifo_in_valid;
  logic            fifo_in_stall;
  logic [IW-1:0]   grant_id;
  logic            locked;
`ifdef CR_KME_FIFO_ARB_WDOG_EN
  logic            wdog_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cr_kme_fifo_arb #(
    .NUM_REQ   (N),
    .DATA_SIZE (DW),
    .ID_W      (IW)
`ifdef CR_KME_FIFO_ARB_WDOG_EN
    ,
    .WDOG_CYCLES (16)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_eop       (req_eop),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
`ifdef CR_KME_FIFO_ARB_WDOG_EN
    .wdog_err      (wdog_err),
`endif
    .grant_id      (grant_id),
    .locked        (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Distinct beat payload for requester i, beat k.
  function automatic logic [DW-1:0] dat(input int i, input int k);
    logic [DW-1:0] v;
    v = {4'(i), 32'hC0DE_0000 | 32'(i << 8) | 32'(k), 96'(k * 1000 + i + 7)};
    return v;
  endfunction

  task automatic drive(input int i, input bit v, input bit e, input int k);
    req_valid[i] = v;
    req_eop[i]   = e;
    req_data[i*DW +: DW] = dat(i, k);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_eop   = '0;
    req_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's write issue: expected one-hot ack and payload.
  task automatic expect_issue(input string tag, input logic [N-1:0] ack, input logic [DW-1:0] d);
    #1;
    check({tag, ".ack"}, DW'(req_ack), DW'(ack));
    check({tag, ".valid"}, DW'(fifo_in_valid), DW'(|ack));
    if (|ack) check({tag, ".data"}, fifo_in, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    fifo_in_stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    fifo_in_stall = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst.locked", DW'(locked), '0);
    check("rst.grant", DW'(grant_id), '0);
    check("rst.ack", DW'(req_ack), '0);
    check("rst.valid", DW'(fifo_in_valid), '0);
    tick();

    // All requesters valid with single-beat packets: 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, c);
      expect_issue($sformatf("rr%0d", c), 4'(1 << (c % 4)), dat(c % 4, c));
      tick();
      check($sformatf("rr%0d.grant", c), DW'(grant_id), DW'(c % 4));
      check($sformatf("rr%0d.locked", c), DW'(locked), '0);
    end

    // 3-beat packet from req0 while req1 is always valid
    do_reset();
    drive(1, 1'b1, 1'b1, 9);
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, b == 2, b);
      expect_issue($sformatf("pkt.b%0d", b), 4'b0001, dat(0, b));
      tick();
      check($sformatf("pkt.b%0d.locked", b), DW'(locked), DW'(b != 2));
    end
    drive(0, 1'b0, 1'b0, 0);
    expect_issue("pkt.req1", 4'b0010, dat(1, 9));
    tick();
    check("pkt.req1.grant", DW'(grant_id), 1);

    // Stall in IDLE, then 5-cycle stall in the middle of a req1 packet
    do_reset();
    drive(3, 1'b1, 1'b1, 0);
    fifo_in_stall = 1'b1;
    drive(1, 1'b1, 1'b0, 0);
    expect_issue("stall.idle", 4'b0000, '0);
    tick();
    check("stall.idle.locked", DW'(locked), '0);
    fifo_in_stall = 1'b0;
    expect_issue("stall.b0", 4'b0010, dat(1, 0));
    tick();
    drive(1, 1'b1, 1'b0, 1);
    expect_issue("stall.b1", 4'b0010, dat(1, 1));
    tick();
    drive(1, 1'b1, 1'b0, 2);
    fifo_in_stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      expect_issue($sformatf("stall.s%0d", s), 4'b0000, '0);
      tick();
      check($sformatf("stall.s%0d.grant", s), DW'(grant_id), 1);
      check($sformatf("stall.s%0d.locked", s), DW'(locked), 1);
    end
    fifo_in_stall = 1'b0;
    expect_issue("stall.b2", 4'b0010, dat(1, 2));
    tick();
    drive(1, 1'b1, 1'b1, 3);
    expect_issue("stall.b3", 4'b0010, dat(1, 3));
    tick();
    check("stall.end.locked", DW'(locked), '0);
    // rr_ptr must now be 2: req0 and req3 valid -> req3 wins
    drive(1, 1'b0, 1'b0, 0);
    drive(0, 1'b1, 1'b1, 5);
    expect_issue("stall.ptr", 4'b1000, dat(3, 0));
    tick();

    // Owner bubble in LOCKED while req2 waits
    do_reset();
    drive(2, 1'b1, 1'b1, 4);
    drive(0, 1'b1, 1'b0, 0);
    expect_issue("bub.b0", 4'b0001, dat(0, 0));
    tick();
    drive(0, 1'b0, 1'b0, 0);
    for (int s = 0; s < 3; s++) begin
      expect_issue($sformatf("bub.s%0d", s), 4'b0000, '0);
      tick();
      check($sformatf("bub.s%0d.locked", s), DW'(locked), 1);
    end
    drive(0, 1'b1, 1'b1, 1);
    expect_issue("bub.b1", 4'b0001, dat(0, 1));
    tick();
    drive(0, 1'b0, 1'b0, 0);
    expect_issue("bub.req2", 4'b0100, dat(2, 4));
    tick();

    // rr_ptr is 3: req3 opens a packet, then reset hits mid-packet
    drive(2, 1'b0, 1'b0, 0);
    drive(3, 1'b1, 1'b0, 0);
    expect_issue("mrst.b0", 4'b1000, dat(3, 0));
    tick();
    check("mrst.locked", DW'(locked), 1);
    drive(3, 1'b1, 1'b0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.async.locked", DW'(locked), '0);
    check("mrst.async.valid", DW'(fifo_in_valid), '0);
    check("mrst.async.ack", DW'(req_ack), '0);
    tick();
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 6);
    rst_n = 1'b1;
    expect_issue("mrst.restart", 4'b0001, dat(0, 6));
    tick();

`ifdef CR_KME_FIFO_ARB_WDOG_EN
    // Watchdog: req1 locks, then goes silent for 16 cycles
    do_reset();
    drive(1, 1'b1, 1'b0, 0);
    expect_issue("wd.b0", 4'b0010, dat(1, 0));
    tick();
    drive(1, 1'b0, 1'b0, 0);
    drive(0, 1'b1, 1'b1, 2);
    drive(2, 1'b1, 1'b1, 3);
    for (int s = 1; s <= 16; s++) begin
      expect_issue($sformatf("wd.s%0d", s), 4'b0000, '0);
      check($sformatf("wd.s%0d.err", s), DW'(wdog_err), '0);
      tick();
    end
    check("wd.err", DW'(wdog_err), 1);
    check("wd.locked", DW'(locked), '0);
    expect_issue("wd.next", 4'b0100, dat(2, 3));
    tick();
    check("wd.err.pulse", DW'(wdog_err), '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
